// File: rtl/cpu_pkg.sv
// Shared ALU-area types and limits for the serial arithmetic units.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_MAX_WIDTH = 32;
    localparam int SUB_CNT_W     = $clog2(SUB_MAX_WIDTH) + 1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// With SERIAL_SUB_OVERFLOW_EN defined, the bundle also carries the signed overflow flag.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;

    modport master (output start_valid, a, b, res_ready,
                    input  start_ready, res_valid, diff, borrow_out, overflow);
    modport slave  (input  start_valid, a, b, res_ready,
                    output start_ready, res_valid, diff, borrow_out, overflow);
`else
    modport master (output start_valid, a, b, res_ready,
                    input  start_ready, res_valid, diff, borrow_out);
    modport slave  (input  start_valid, a, b, res_ready,
                    output start_ready, res_valid, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor; two of these plus an OR make a full subtractor.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b;
    assign borrow = ~a & b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first, one bit per clock; result valid WIDTH edges after accept.
// Optional SERIAL_SUB_OVERFLOW_EN adds a signed two's-complement overflow flag.
module serial_subtractor
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    sub_state_t           state, state_nxt;
    logic [WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-1:0]     diff_q;
    logic                 bor;
    logic [SUB_CNT_W-1:0] cnt;

    logic d_half, br_half, d_bit, br_full, bor_nxt;

    // Full-subtractor slice: first cell takes a - b, second subtracts the incoming borrow.
    half_subtractor u_hs0 (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .diff   (d_half),
        .borrow (br_half)
    );

    half_subtractor u_hs1 (
        .a      (d_half),
        .b      (bor),
        .diff   (d_bit),
        .borrow (br_full)
    );

    assign bor_nxt = br_half | br_full;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == SUB_CNT_W'(WIDTH - 1)) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        bor  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    bor    <= bor_nxt;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.diff        = diff_q;
    assign bus.borrow_out  = bor;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb, b_msb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && bus.start_valid) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end
    end

    // Signed overflow: operands of differing sign and a result whose sign differs from a.
    assign bus.overflow = (state == DONE) && (a_msb != b_msb) && (diff_q[WIDTH-1] != a_msb);
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands, computes a - b LSB-first at one bit per clock, and returns the difference and the final borrow.
- Arithmetic counterpart to the adder cells. Its datapath is one full-subtractor slice built from two half-subtractor cells plus a borrow flip-flop.
- Sits in the ALU area as a low-area subtract unit behind valid/ready handshakes.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start_valid  input  1  operands a/b valid
start_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
res_valid  output  1  diff/borrow_out valid
res_ready  input  1  consumer accepts result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow_out  output  1  1 when a < b (unsigned)

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, start_ready=1, res_valid=0, diff=0, borrow_out=0, bit counter=0, borrow register=0.
- States and transitions:
  - IDLE: start_ready=1. When start_valid&&start_ready at an edge: latch a and b into shift registers, clear the borrow register and the counter, go to SHIFT.
  - SHIFT: start_ready=0, res_valid=0. Each edge:
    - d = a0^b0^bor
    - bor_next = (~a0&b0) | (~(a0^b0)&bor)
    - shift a and b right by 1; shift d into the MSB of the diff register; counter++
    - When counter reaches WIDTH-1, the same edge goes to DONE.
  - DONE: res_valid=1. diff holds the full result; borrow_out = final borrow. When res_ready is sampled high: go to IDLE, res_valid drops on that edge.
- Latency: res_valid rises exactly WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- Start handling: start_ready is high only in IDLE. No overlap of result and new start; start_valid in SHIFT/DONE is ignored (not consumed).
- Hold rule: while res_valid && !res_ready, diff and borrow_out are stable.
- Output validity: diff and borrow_out are undefined-but-deterministic (shifting contents) outside DONE. Consumers may only sample them with res_valid.
- Input latching: a and b are sampled only on the accepting edge; later changes have no effect.
- Boundary cases:
  - a==b gives diff=0, borrow_out=0.
  - b==0 gives diff=a, borrow_out=0.
  - a=0,b=all-ones gives diff=1, borrow_out=1.
- Reset mid-operation (SHIFT or DONE): result is discarded, and all reset values apply on the next edge.

Optional Feature:
Macro: SERIAL_SUB_OVERFLOW_EN
- Defined:
  - Adds output port `overflow` (1 bit), reset 0.
  - a[WIDTH-1] and b[WIDTH-1] are latched at accept.
  - In DONE: overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb), i.e. signed two's-complement overflow.
  - overflow is held with diff.
- Undefined: the port and the latch registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - state enum typedef sub_state_t {IDLE, SHIFT, DONE}
  - constant SUB_MAX_WIDTH=32
- Sub-module half_subtractor (a, b, diff=a^b, borrow=~a&b). Two instances plus an OR form the per-bit full subtractor; the rest stays in serial_subtractor.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> start_ready=1, res_valid=0, diff=0x00, borrow_out=0.
- Basic subtract (WIDTH=8): a=0x05, b=0x03 accepted -> res_valid high exactly 8 edges later, diff=0x02, borrow_out=0. Also a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- Backpressure: a=0x80, b=0x01, res_ready held 0 for 5 cycles -> diff=0x7F held stable; start_valid pulses ignored; overflow=1 when SERIAL_SUB_OVERFLOW_EN.
- Back-to-back: start_valid held high with two operand pairs (0x10-0x10, 0x33-0x11), res_ready=1 -> results 0x00/b0 then 0x22/b0; second accept occurs only after return to IDLE.
- Reset mid-SHIFT: accept 0xAA-0x55, assert rst_n=0 at bit 4 -> next edge IDLE, res_valid never asserts. A new op 0x0F-0x01 then yields 0x0E.
- Random sweep: 1000 random a/b pairs compared against a reference model for a-b mod 256 and a<b.
